// File: rtl/cp0_exc_ctrl_pkg.sv
// rtl/cp0_exc_ctrl_pkg.sv - shared CP0 register numbers, ExcCodes and bit positions
// Ports: none (package).
package cp0_exc_ctrl_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   localparam int SR_IM_LO  = 10;
   localparam int SR_IM_HI  = 15;
   localparam int SR_EXL    = 1;
   localparam int SR_IE     = 0;
   localparam int CAUSE_BD  = 31;
   localparam int CAUSE_IP_LO = 10;
   localparam int CAUSE_IP_HI = 15;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
   localparam logic [31:0] PRID_VAL_DEF     = 32'h0000_2017;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt responder with SR, Cause, EPC, PRId
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   addr, we, din, dout   mfc0/mtc0 register access (dout combinational on addr)
//   victim_pc, bd_in      M-stage PC and branch-delay-slot flag
//   exc_valid, exc_code   M-stage synchronous exception request
//   hw_int                level-sensitive external interrupt lines
//   eret                  M-stage eret
//   int_req               take exception this cycle
//   handler_pc, epc_out   exception vector and eret redirect target
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
   parameter logic [31:0] PRID_VAL     = PRID_VAL_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic [31:0] victim_pc,
   input  logic        bd_in,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [5:0]  hw_int,
   input  logic        eret,
   output logic        int_req,
   output logic [31:0] handler_pc,
   output logic [31:0] epc_out
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        irq_hit;
   logic        exc_hit;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign irq_hit = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
   assign exc_hit = exc_valid & ~sr_exl;
   // Gated by reset so a request present during reset never reaches the PC.
   assign int_req = ~reset & (irq_hit | exc_hit);

   assign handler_pc = HANDLER_ADDR;
   assign epc_out    = epc;

   assign sr_val    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
   assign cause_val = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

   always_comb begin
      dout = 32'd0;
      case (addr)
         CP0_SR:    dout = sr_val;
         CP0_CAUSE: dout = cause_val;
         CP0_EPC:   dout = epc;
         CP0_PRID:  dout = PRID_VAL;
         default:   dout = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= 6'd0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'd0;
         cause_exc <= 5'd0;
         epc       <= 32'd0;
      end else begin
         // Pending-interrupt view tracks the lines every cycle, entry included.
         cause_ip <= hw_int;
         if (int_req) begin
            // Exception entry owns the cycle; any concurrent mtc0 is dropped.
            sr_exl    <= 1'b1;
            cause_bd  <= bd_in;
            epc       <= bd_in ? victim_pc - 32'd4 : victim_pc;
            cause_exc <= irq_hit ? EXC_INT : exc_code;
         end else begin
            if (we && addr == CP0_SR) begin
               sr_im  <= din[SR_IM_HI:SR_IM_LO];
               sr_exl <= din[SR_EXL];
               sr_ie  <= din[SR_IE];
            end
            if (we && addr == CP0_EPC) begin
               epc <= din;
            end
            // Placed after the SR write so eret clears EXL over a written value.
            if (eret) begin
               sr_exl <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking scoreboard bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic [31:0] victim_pc;
   logic        bd_in;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [5:0]  hw_int;
   logic        eret;
   logic        int_req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   int checks = 0;
   int failures = 0;

   string       name_q[$];
   logic [31:0] val_q[$];
   string       e_name;
   logic [31:0] e_val;
   logic [31:0] obs;

   cp0_exc_ctrl dut (
      .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout),
      .victim_pc(victim_pc), .bd_in(bd_in), .exc_valid(exc_valid),
      .exc_code(exc_code), .hw_int(hw_int), .eret(eret), .int_req(int_req),
      .handler_pc(handler_pc), .epc_out(epc_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string n, input logic [31:0] v);
      name_q.push_back(n);
      val_q.push_back(v);
   endtask

   task automatic pop_exp();
      e_name = name_q.pop_front();
      e_val  = val_q.pop_front();
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = dout;
   endtask

   task automatic test_reset();
      reset = 1'b1; we = 1'b0; din = 0; addr = 5'd12; victim_pc = 0; bd_in = 0;
      exc_valid = 1'b1; exc_code = 5'd12; hw_int = 6'h3F; eret = 0;
      tick(); tick();
      push_exp("reset_int_req", 32'd0);
      #1; pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      exc_valid = 1'b0; hw_int = 6'd0;
      push_exp("reset_sr", 32'd0); push_exp("reset_cause", 32'd0); push_exp("reset_epc", 32'd0);
      push_exp("handler_pc", 32'h0000_4180);
      reset = 1'b0;
      read_reg(5'd12, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd13, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      pop_exp(); checks++;
      if (handler_pc !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, handler_pc, e_val); end
   endtask

   task automatic test_irq();
      addr = 5'd12; we = 1'b1; din = 32'h0000_FC01;
      push_exp("sr_write", 32'h0000_FC01);
      tick(); we = 1'b0;
      read_reg(5'd12, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      hw_int = 6'b000100; victim_pc = 32'h0000_0100;
      push_exp("irq_int_req", 32'd1);
      #1; pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      push_exp("irq_sr", 32'h0000_FC03); push_exp("irq_cause", 32'h0000_1000);
      push_exp("irq_epc", 32'h0000_0100); push_exp("irq_int_req_drop", 32'd0);
      tick();
      read_reg(5'd12, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd13, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      hw_int = 6'd0; eret = 1'b1; tick(); eret = 1'b0;
   endtask

   task automatic test_exc();
      addr = 5'd12; we = 1'b1; din = 32'h0000_0001; tick(); we = 1'b0;
      hw_int = 6'h3F;
      push_exp("masked_int_req", 32'd0);
      #1; pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      exc_valid = 1'b1; exc_code = 5'd12; victim_pc = 32'h0000_3010;
      push_exp("ov_int_req", 32'd1);
      #1; pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      push_exp("ov_cause", 32'h0000_FC30); push_exp("ov_epc", 32'h0000_3010);
      tick(); exc_valid = 1'b0;
      read_reg(5'd13, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      hw_int = 6'd0; eret = 1'b1; tick(); eret = 1'b0;
   endtask

   task automatic test_bd_and_nesting();
      bd_in = 1'b1; victim_pc = 32'h0000_3024; exc_valid = 1'b1; exc_code = 5'd4;
      push_exp("bd_epc", 32'h0000_3020); push_exp("bd_cause", 32'h8000_0010);
      tick(); bd_in = 1'b0;
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd13, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      // EXL=1 here: a further exception must be ignored.
      exc_code = 5'd10; victim_pc = 32'h0000_5000;
      push_exp("nested_int_req", 32'd0); push_exp("nested_epc", 32'h0000_3020);
      #1; pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      tick(); exc_valid = 1'b0;
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      eret = 1'b1;
      push_exp("eret_sr", 32'h0000_0001); push_exp("eret_epc_out", 32'h0000_3020);
      tick(); eret = 1'b0;
      read_reg(5'd12, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      pop_exp(); checks++;
      if (epc_out !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, epc_out, e_val); end
   endtask

   task automatic test_simultaneous();
      addr = 5'd12; we = 1'b1; din = 32'h0000_FC01; tick();
      hw_int = 6'b000001; exc_valid = 1'b1; exc_code = 5'd10; victim_pc = 32'h0000_6000;
      addr = 5'd14; we = 1'b1; din = 32'h0000_1234;
      push_exp("simul_cause", 32'h0000_0400); push_exp("simul_epc", 32'h0000_6000);
      tick(); we = 1'b0; exc_valid = 1'b0;
      read_reg(5'd13, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      // mtc0 SR with EXL set, same cycle as eret: write lands, EXL cleared.
      hw_int = 6'd0; addr = 5'd12; we = 1'b1; din = 32'hFFFF_FC03; eret = 1'b1;
      push_exp("eret_mtc0_sr", 32'h0000_FC01);
      tick(); we = 1'b0; eret = 1'b0;
      read_reg(5'd12, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      addr = 5'd14; we = 1'b1; din = 32'h0000_3403;
      push_exp("epc_low_bits", 32'h0000_3403);
      tick(); we = 1'b0;
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      addr = 5'd15; we = 1'b1; din = 32'hDEAD_BEEF;
      push_exp("prid", 32'h0000_2017); push_exp("unimpl", 32'd0);
      tick(); we = 1'b0;
      read_reg(5'd15, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd20, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
   endtask

   task automatic test_wrap_and_reset();
      bd_in = 1'b1; victim_pc = 32'd0; exc_valid = 1'b1; exc_code = 5'd5;
      push_exp("wrap_epc", 32'hFFFF_FFFC);
      tick(); bd_in = 1'b0; exc_valid = 1'b0;
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      addr = 5'd14; we = 1'b1; din = 32'h0000_3400; tick(); we = 1'b0;
      reset = 1'b1; exc_valid = 1'b1; hw_int = 6'h3F;
      push_exp("rst_int_req", 32'd0); push_exp("rst_sr", 32'd0);
      push_exp("rst_cause", 32'd0); push_exp("rst_epc", 32'd0);
      tick();
      pop_exp(); checks++;
      if ({31'd0, int_req} !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, int_req, e_val); end
      read_reg(5'd12, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd13, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      read_reg(5'd14, obs); pop_exp(); checks++;
      if (obs !== e_val) begin failures++; $display("FAIL %s got=%h exp=%h", e_name, obs, e_val); end
      exc_valid = 1'b0; hw_int = 6'd0; reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_irq();
      test_exc();
      test_bd_and_nesting();
      test_simultaneous();
      test_wrap_and_reset();
      checks++;
      if (name_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", name_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt responder for the pipelined MIPS core.
- Consumes exception requests from the pipeline, including fetch-address faults raised by the PC register, plus external hardware interrupt lines.
- Decides when to take an exception and asserts int_req, which forces the PC register to load the handler address even while the pipeline is stalled.
- Holds SR, Cause, EPC and PRId, and serves mfc0/mtc0/eret.

Parameters:
HANDLER_ADDR, 32'h0000_4180, exception vector driven on handler_pc.
PRID_VAL, 32'h0000_2017, read-only PRId contents.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
addr  in  5  CP0 register number for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC, 15 PRId)
we  in  1  mtc0 write enable
din  in  32  mtc0 write data
dout  out  32  mfc0 read data (combinational on addr)
victim_pc  in  32  PC of the instruction in the M stage
bd_in  in  1  M-stage instruction is in a branch delay slot
exc_valid  in  1  M-stage instruction carries an exception
exc_code  in  5  ExcCode of that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov)
hw_int  in  6  external interrupt lines, level-sensitive
eret  in  1  M-stage eret
int_req  out  1  take exception this cycle (flush pipeline, load handler_pc)
handler_pc  out  32  HANDLER_ADDR
epc_out  out  32  current EPC, used as the eret redirect target

Behaviour:
- Reset values:
  - SR = 0, with IM[15:10]=0, EXL[1]=0, IE[0]=0.
  - Cause = 0.
  - EPC = 0.
  - dout follows addr; int_req = 0 while reset is held.
- SR: only bits 15:10, 1, 0 are writable. All other bits read 0.
- Cause: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0. Cause is not writable by mtc0 (writes ignored).
- IP[15:10] <= hw_int every cycle, including during exception entry. The reset cycle is the only exception.
- EPC: bits [1:0] are writable and held as written. Reads return the full 32 bits.
- PRId and unimplemented addresses: writes ignored. Reads return PRID_VAL for 15, otherwise 0.
- int_req, combinational and gated by reset:
  - irq_hit = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_hit = exc_valid & ~SR.EXL
  - int_req = irq_hit | exc_hit
- Exception entry, at the clock edge where int_req=1:
  - EXL <= 1.
  - BD <= bd_in.
  - EPC <= bd_in ? victim_pc - 4 : victim_pc. Arithmetic is 32-bit and wraps.
  - ExcCode <= irq_hit ? 0 : exc_code. Interrupts have priority over synchronous exceptions.
  - Single-cycle effect. int_req drops the next cycle because EXL=1.
- eret (with int_req=0): EXL <= 0. EPC is unchanged. The pipeline redirects to epc_out.
- Simultaneous events:
  - int_req and mtc0 in the same cycle: the exception-entry updates win and the mtc0 write is discarded entirely.
  - mtc0 to SR and eret in the same cycle: the written value is applied, then EXL is cleared.
  - exc_valid while EXL=1: ignored (no nesting). Nothing is recorded.
- Reset mid-exception: all state returns to reset values on the next edge. Any pending int_req is lost.
- Latency:
  - mtc0 write becomes visible on dout the cycle after we.
  - SR.IM/IE changes affect int_req the cycle after the write.

Decomposition:
- Shared package:
  - CP0 register numbers (12–15).
  - ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12).
  - SR/Cause bit-position constants.
  - HANDLER_ADDR default.
- No sub-module is needed. The single module holds the register file, int_req logic and read mux.
- An optional cp0_irq_arb helper computing irq_hit/exc_hit is acceptable but not required.

Test Plan:
1. Reset, then mtc0 SR = 32'h0000_FC01 -> dout at addr 12 reads 32'h0000_FC01 next cycle. Then raise hw_int = 6'b000100 -> int_req=1 that cycle. Next cycle: EXL=1, Cause.ExcCode=0, Cause.IP=6'b000100, EPC=victim_pc, int_req=0.
2. SR = 32'h0000_0001 (IM=0), hw_int=6'h3F -> int_req stays 0. Then exc_valid=1, exc_code=12, victim_pc=32'h0000_3010 -> int_req=1. Then Cause[6:2]=12 and EPC=32'h0000_3010.
3. bd_in=1, victim_pc=32'h0000_3024, exc_valid=1, exc_code=4 -> EPC=32'h0000_3020, Cause[31]=1.
4. With EXL=1: exc_valid=1 -> int_req=0 and EPC unchanged. Then eret -> EXL=0 next cycle, epc_out unchanged.
5. Same cycle: irq_hit with exc_valid (exc_code=10) and mtc0 EPC=32'h1234 -> ExcCode=0, EPC=victim_pc, and the write is discarded.
6. Assert reset while EXL=1 and EPC=32'h0000_3400 -> SR, Cause and EPC all read 0 next cycle, and int_req=0.
